// File: rtl/axil_write.sv
// ---------------------------------------------------------------------------
// axil_write -- AXI4-Lite single-beat write master.
//
// Takes one write request (address, data, byte strobes) from a local config
// port and runs it over the AW, W and B channels. The slave's BRESP goes back
// to the config side together with a one-cycle done pulse. A response
// watchdog aborts a transaction that hangs in SEND/RESP. When it fires,
// cfg_bresp reads SLVERR (2'b10) and cfg_timeout pulses with cfg_wdone.
//
// Parameters:
//   ADDR_WIDTH      address width
//   DATA_WIDTH      data width, 32 or 64; strobe width is DATA_WIDTH/8
//   TIMEOUT_CYCLES  cycles allowed in SEND+RESP before abort, 0 = no watchdog
//
// Ports:
//   s_axi_aclk, s_axi_areset           clock, async active-high reset
//   s_axi_aw*                          write address channel (master side)
//   s_axi_w*                           write data channel (master side)
//   s_axi_b*                           write response channel (master side)
//   s_axi_cfg_wvalid/waddr/wdata/wstrb request strobe and payload
//   s_axi_cfg_wready                   high while idle (request accepted)
//   s_axi_cfg_wdone/bresp/timeout      completion pulse, response, abort flag
// ---------------------------------------------------------------------------
module axil_write #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    output logic [2:0]              s_axi_awprot,
    output logic                    s_axi_awvalid,
    input  logic                    s_axi_awready,
    output logic [DATA_WIDTH-1:0]   s_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                    s_axi_wvalid,
    input  logic                    s_axi_wready,
    input  logic                    s_axi_bvalid,
    input  logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bready,
    input  logic                    s_axi_cfg_wvalid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_cfg_waddr,
    input  logic [DATA_WIDTH-1:0]   s_axi_cfg_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_cfg_wstrb,
    output logic                    s_axi_cfg_wready,
    output logic                    s_axi_cfg_wdone,
    output logic [1:0]              s_axi_cfg_bresp,
    output logic                    s_axi_cfg_timeout
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // Counter must hold TIMEOUT_CYCLES itself (value after the last increment).
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wdone;
    logic                  r_timeout;
    logic [1:0]            r_bresp;

    logic w_busy;
    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_aw_all;
    logic w_w_all;
    logic w_expire;

    assign w_busy   = (r_state == ST_SEND) || (r_state == ST_RESP);
    assign w_accept = s_axi_cfg_wvalid && (r_state == ST_IDLE);
    assign w_aw_hs  = r_awvalid && s_axi_awready;
    assign w_w_hs   = r_wvalid && s_axi_wready;
    assign w_b_hs   = r_bready && s_axi_bvalid;
    // A channel counts as complete if it finished earlier or finishes now.
    assign w_aw_all = r_aw_done || w_aw_hs;
    assign w_w_all  = r_w_done || w_w_hs;
    assign w_expire = (TIMEOUT_CYCLES != 0) && w_busy && (r_cnt == CNT_LAST);

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state   <= ST_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= '0;
            r_wdone   <= 1'b0;
            r_timeout <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            r_wdone   <= 1'b0;
            r_timeout <= 1'b0;
            if ((TIMEOUT_CYCLES != 0) && w_busy)
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_awaddr  <= s_axi_cfg_waddr;
                        r_wdata   <= s_axi_cfg_wdata;
                        r_wstrb   <= s_axi_cfg_wstrb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // No B handshake is possible here (bready low), so expiry
                    // always aborts, even if AW/W complete this same cycle.
                    if (w_expire) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b0;
                        r_wdone   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_bresp   <= 2'b10;
                        r_state   <= ST_IDLE;
                    end else begin
                        if (w_aw_hs) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if (w_aw_all && w_w_all) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    // A response landing on the expiry cycle wins over abort.
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_bresp  <= s_axi_bresp;
                        r_wdone  <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (w_expire) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b0;
                        r_wdone   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_bresp   <= 2'b10;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axi_awaddr      = r_awaddr;
    assign s_axi_awprot      = 3'b000;
    assign s_axi_awvalid     = r_awvalid;
    assign s_axi_wdata       = r_wdata;
    assign s_axi_wstrb       = r_wstrb;
    assign s_axi_wvalid      = r_wvalid;
    assign s_axi_bready      = r_bready;
    assign s_axi_cfg_wready  = (r_state == ST_IDLE);
    assign s_axi_cfg_wdone   = r_wdone;
    assign s_axi_cfg_bresp   = r_bresp;
    assign s_axi_cfg_timeout = r_timeout;

endmodule

// File: tb/tb_axil_write.sv
module tb_axil_write;
    localparam int TO = 8;

    logic        clk, rst;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        cfg_wvalid;
    logic [31:0] cfg_waddr, cfg_wdata;
    logic [3:0]  cfg_wstrb;
    logic        cfg_wready, cfg_wdone, cfg_timeout;
    logic [1:0]  cfg_bresp;

    int errors = 0;
    int checks = 0;

    // Slave behaviour: each ready/valid comes after a programmable number of
    // cycles of the corresponding master signal being high.
    int da = 0, dw = 0, db = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [1:0] slv_bresp = 2'b00;

    assign awready = (aw_cnt >= da);
    assign wready  = (w_cnt >= dw);
    assign bvalid  = bready && (b_cnt >= db);
    assign bresp   = slv_bresp;

    always @(posedge clk) begin
        aw_cnt <= awvalid ? aw_cnt + 1 : 0;
        w_cnt  <= wvalid  ? w_cnt + 1  : 0;
        b_cnt  <= bready  ? b_cnt + 1  : 0;
    end

    axil_write #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
        .s_axi_cfg_wvalid(cfg_wvalid), .s_axi_cfg_waddr(cfg_waddr),
        .s_axi_cfg_wdata(cfg_wdata), .s_axi_cfg_wstrb(cfg_wstrb),
        .s_axi_cfg_wready(cfg_wready), .s_axi_cfg_wdone(cfg_wdone),
        .s_axi_cfg_bresp(cfg_bresp), .s_axi_cfg_timeout(cfg_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One write transaction. Called at a negedge; returns at the negedge of
    // the done cycle so a following call gives a back-to-back accept.
    // Expected timing is derived from the slave delays: cycle n is the n-th
    // cycle after the accept edge, SEND starts in cycle 1.
    task automatic run_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input int a, input int w, input int b,
                             input logic [1:0] br, input bit junk);
        int mx, exp_done, exp_aw, exp_w, exp_b;
        int done_n, awc, wc, first_b, bad;
        bit normal;
        logic [1:0] exp_br, got_br;
        logic got_to;
        mx = (a > w) ? a : w;
        // B handshake happens in cycle 2+mx+b, watchdog counter there is 1+mx+b.
        normal   = (1 + mx + b) <= (TO - 1);
        exp_done = normal ? (3 + mx + b) : (TO + 1);
        exp_br   = normal ? br : 2'b10;
        exp_aw   = ((a + 1) < (exp_done - 1)) ? (a + 1) : (exp_done - 1);
        exp_w    = ((w + 1) < (exp_done - 1)) ? (w + 1) : (exp_done - 1);
        exp_b    = (mx < TO - 1) ? (2 + mx) : 0;
        done_n = 0; awc = 0; wc = 0; first_b = 0; bad = 0;
        got_br = 2'bxx; got_to = 1'bx;

        da = a; dw = w; db = b; slv_bresp = br;
        cfg_wvalid = 1'b1; cfg_waddr = addr; cfg_wdata = data; cfg_wstrb = strb;
        if (cfg_wready !== 1'b1) bad++;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (junk) begin
                cfg_waddr = $urandom; cfg_wdata = $urandom; cfg_wstrb = 4'($urandom);
            end else begin
                cfg_wvalid = 1'b0;
            end
            if (awvalid) begin awc++; if (awaddr !== addr) bad++; end
            if (wvalid) begin
                wc++;
                if (wdata !== data || wstrb !== strb) bad++;
            end
            if (bready && first_b == 0) first_b = n;
            if (cfg_wdone) begin
                done_n = n; got_br = cfg_bresp; got_to = cfg_timeout;
                if (awvalid || wvalid || bready || !cfg_wready) bad++;
                break;
            end
            if (cfg_wready || cfg_timeout) bad++;
        end
        cfg_wvalid = 1'b0;

        checks++; if (done_n !== exp_done) begin errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", tag, done_n, exp_done); end
        checks++; if (got_br !== exp_br) begin errors++;
            $display("FAIL %s bresp: got %b want %b", tag, got_br, exp_br); end
        checks++; if (got_to !== !normal) begin errors++;
            $display("FAIL %s timeout: got %b want %b", tag, got_to, !normal); end
        checks++; if (awc !== exp_aw) begin errors++;
            $display("FAIL %s awvalid_cycles: got %0d want %0d", tag, awc, exp_aw); end
        checks++; if (wc !== exp_w) begin errors++;
            $display("FAIL %s wvalid_cycles: got %0d want %0d", tag, wc, exp_w); end
        checks++; if (first_b !== exp_b) begin errors++;
            $display("FAIL %s bready_cycle: got %0d want %0d", tag, first_b, exp_b); end
        checks++; if (bad !== 0) begin errors++;
            $display("FAIL %s protocol_violations: got %0d want 0", tag, bad); end
        checks++; if (awaddr !== addr || wdata !== data || wstrb !== strb) begin errors++;
            $display("FAIL %s bus_hold: got %h/%h/%h want %h/%h/%h", tag,
                     awaddr, wdata, wstrb, addr, data, strb); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_wvalid = 1'b0; cfg_waddr = '0; cfg_wdata = '0; cfg_wstrb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, cfg_wdone, cfg_timeout} !== 5'b0 ||
            awaddr !== 32'h0 || wdata !== 32'h0 || wstrb !== 4'h0 ||
            cfg_bresp !== 2'b00 || awprot !== 3'b000 || cfg_wready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b%b%b d=%b t=%b a=%h d=%h s=%h br=%b p=%b rdy=%b want zeros, rdy=1",
                     awvalid, wvalid, bready, cfg_wdone, cfg_timeout, awaddr, wdata,
                     wstrb, cfg_bresp, awprot, cfg_wready);
        end
    endtask

    task automatic test_zero_wait();
        run_write("zero_wait", 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
        checks++;
        if (cfg_wdone !== 1'b0) begin errors++;
            $display("FAIL wdone_pulse_width: got %b want 0", cfg_wdone); end
    endtask

    task automatic test_aw_delay();
        run_write("aw_delay", 32'h0000_0100, 32'h1234_5678, 4'hF, 4, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_w_delay();
        run_write("w_delay", 32'h0000_0204, 32'hCAFE_F00D, 4'h3, 0, 3, 0, 2'b00, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_error_resp();
        run_write("decerr", 32'h0000_0300, 32'h0BAD_0BAD, 4'hC, 1, 2, 1, 2'b11, 1'b0);
        @(negedge clk);
        run_write("slverr", 32'h0000_0304, 32'h0000_0001, 4'h1, 0, 0, 2, 2'b10, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        run_write("to_no_b", 32'h0000_0400, 32'h5555_AAAA, 4'hF, 0, 0, 100, 2'b00, 1'b0);
        @(negedge clk);
        run_write("to_b_last_ok", 32'h0000_0404, 32'h1111_2222, 4'hF, 0, 0, 6, 2'b01, 1'b0);
        @(negedge clk);
        run_write("to_b_late", 32'h0000_0408, 32'h3333_4444, 4'hF, 0, 0, 7, 2'b00, 1'b0);
        @(negedge clk);
        run_write("to_in_send", 32'h0000_040C, 32'h7777_8888, 4'hF, 7, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_ignored_requests();
        run_write("ignored", 32'h0000_0500, 32'hA5A5_5A5A, 4'h9, 2, 1, 2, 2'b00, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_write("b2b_0", 32'h0000_0600, 32'h0000_0600, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        run_write("b2b_1", 32'h0000_0604, 32'h0000_0604, 4'h5, 0, 0, 0, 2'b01, 1'b0);
        run_write("b2b_2", 32'h0000_0608, 32'h0000_0608, 4'hA, 1, 0, 1, 2'b00, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        da = 50; dw = 0; db = 0;
        cfg_wvalid = 1'b1; cfg_waddr = 32'h0000_0700; cfg_wdata = 32'hFFFF_0000; cfg_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cfg_wvalid = 1'b0;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin errors++;
            $display("FAIL areset_pre: got aw=%b w=%b want 1 1", awvalid, wvalid); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || cfg_wready !== 1'b1) begin
            errors++;
            $display("FAIL areset_async: got aw=%b w=%b b=%b rdy=%b want 0 0 0 1",
                     awvalid, wvalid, bready, cfg_wready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_write("after_reset", 32'h0000_0710, 32'h0F0F_0F0F, 4'hF, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 14; i++) begin
            run_write($sformatf("rand%0d", i), $urandom, $urandom, 4'($urandom_range(1, 15)),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_zero_wait();
        test_aw_delay();
        test_w_delay();
        test_error_resp();
        test_timeout();
        test_ignored_requests();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axil_write.md
Name: axil_write

Overview:
- AXI4-Lite write master, the write-direction companion to the team's AXI-lite read master; shares the same config-side request style.
- Accepts one single-beat write request (address, data, byte strobes) from a local config port and drives AW, W and B to the slave.
- Returns the slave's BRESP to the config side with a one-cycle done pulse.
- A response watchdog aborts a hung transaction.

Parameters:
- ADDR_WIDTH, 32, width of the AXI and config addresses.
- DATA_WIDTH, 32, data width; must be 32 or 64. Strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, cycles allowed in SEND+RESP before abort; 0 disables the watchdog.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  asynchronous reset, active-high
- s_axi_awaddr  out  ADDR_WIDTH  write address
- s_axi_awprot  out  3  constant 3'b000
- s_axi_awvalid  out  1  address valid
- s_axi_awready  in  1  address ready
- s_axi_wdata  out  DATA_WIDTH  write data
- s_axi_wstrb  out  DATA_WIDTH/8  byte strobes
- s_axi_wvalid  out  1  data valid
- s_axi_wready  in  1  data ready
- s_axi_bvalid  in  1  response valid
- s_axi_bresp  in  2  response code
- s_axi_bready  out  1  response ready
- s_axi_cfg_wvalid  in  1  write request strobe
- s_axi_cfg_waddr  in  ADDR_WIDTH  request address
- s_axi_cfg_wdata  in  DATA_WIDTH  request data
- s_axi_cfg_wstrb  in  DATA_WIDTH/8  request strobes
- s_axi_cfg_wready  out  1  ready to accept a request
- s_axi_cfg_wdone  out  1  one-cycle completion pulse
- s_axi_cfg_bresp  out  2  response code, valid with wdone
- s_axi_cfg_timeout  out  1  one-cycle pulse on watchdog abort, coincident with wdone

Behaviour:
- Reset (asynchronous, any state): state=IDLE; awvalid, wvalid, bready, cfg_wdone, cfg_timeout=0; awaddr, wdata, wstrb, cfg_bresp=0; aw_done, w_done flags and watchdog counter=0.
- cfg_wready = (state==IDLE), combinational. A request is accepted when cfg_wvalid && cfg_wready. Requests presented outside IDLE are ignored, not queued.
- IDLE:
  - On accept, register addr, data and strb onto the AXI outputs.
  - Next cycle: awvalid=1, wvalid=1, clear both flags and the counter, go to SEND.
  - Outside SEND, awaddr, wdata and wstrb hold their last value (not zeroed).
- SEND: AW and W are independent channels.
  - awvalid stays high until the cycle sampling awvalid&&awready, then drops and aw_done is set. W works the same way with w_done.
  - Either order or the same cycle is legal.
  - Once both handshakes are complete (counting a handshake in the current cycle), bready=1 registered next cycle and go to RESP.
  - bvalid seen while in SEND is ignored.
- RESP: on bvalid&&bready:
  - bready drops next cycle.
  - cfg_bresp<=s_axi_bresp and cfg_wdone=1 for exactly one cycle.
  - Return to IDLE; cfg_wready is high in that same cycle.
  - Any BRESP value, including SLVERR or DECERR, is passed through unmodified.
- Latency with zero-wait slave (awready=wready=1; bvalid asserted the cycle bready rises):
  - accept at cycle T
  - AW/W handshake at T+1
  - bready at T+2
  - wdone at T+3
  - next accept possible at T+3
- Watchdog:
  - The counter increments every cycle in SEND or RESP.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no completing B handshake that cycle: next cycle deassert awvalid, wvalid and bready, pulse cfg_wdone and cfg_timeout, cfg_bresp=2'b10, go to IDLE.
  - A B handshake in the same cycle as expiry wins: normal completion, no timeout pulse.
- Counter width is clog2(TIMEOUT_CYCLES+1). No wrap occurs because the abort fires first.

Test Plan:
- Zero-wait slave, cfg write addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF → AW/W handshake at T+1, wdone at T+3, cfg_bresp=2'b00, awaddr=0x10, wdata=0xDEADBEEF on bus.
- awready delayed 4 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 5 cycles, bready rises only after AW handshake, wdone with bresp=2'b00.
- wready delayed 3 cycles after AW accepted, strb 0x3 → wstrb=0x3 held stable while wvalid high; single completion.
- Slave returns bresp=2'b11 → cfg_bresp=2'b11, cfg_timeout=0.
- TIMEOUT_CYCLES=8, slave never asserts bvalid → cfg_wdone and cfg_timeout pulse 8 cycles after SEND entry, bresp=2'b10, bready=0, cfg_wready=1 after.
- Assert s_axi_areset mid-SEND with awvalid=1 → awvalid, wvalid, bready drop immediately (asynchronous); after release, cfg_wready=1 and a new write completes normally.
